sfu_ctrl: RTL and testbench
===========================

SFU_CTRL -- requirements
Module: sfu_ctrl

Interface
REQ-001 SHALL have parameter psum_bw, default 16, meaning bits per partial sum.
REQ-002 SHALL have parameter col, default 8, meaning SFU lanes per SRAM word.
REQ-003 SHALL have parameter kij_num, default 9, meaning kernel positions accumulated per output.
REQ-004 SHALL have parameter o_ni_dim, default 16, meaning output pixels per run.
REQ-005 SHALL have parameter addr_bw, default 11, meaning psum SRAM address width.
REQ-006 SHALL have port clk, input, 1, meaning sole clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-low reset (0 = reset).
REQ-008 SHALL have port start, input, 1, meaning run request, sampled in IDLE only.
REQ-009 SHALL have port relu_en, input, 1, meaning apply ReLU before writeback, captured when start is accepted.
REQ-010 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, meaning one-cycle pulse at run end.
REQ-012 SHALL have port sram_cen, output, 1, meaning active-low SRAM chip enable.
REQ-013 SHALL have port sram_wen, output, 1, meaning active-low SRAM write enable.
REQ-014 SHALL have port sram_addr, output, addr_bw, meaning SRAM address.
REQ-015 SHALL have port sram_q, input, col*psum_bw, meaning SRAM read data, valid one cycle after a read.
REQ-016 SHALL have port sram_d, output, col*psum_bw, meaning SRAM write data.
REQ-017 SHALL have port sfu_in, output, col*psum_bw, meaning data to SFU lanes, combinationally equal to sram_q.
REQ-018 SHALL have port sfu_out, input, col*psum_bw, meaning registered SFU lane results.
REQ-019 SHALL have ports sfu_clr, sfu_acc, sfu_relu, output, 1 each, meaning SFU clear, accumulate and ReLU strobes (active-high).

Function
REQ-020 SHALL implement FSM states IDLE, CLR, READ, DRAIN, RELU, WRITE, DONE.
REQ-021 SHALL leave IDLE for CLR on start=1 with o_idx=0; start while busy SHALL be ignored.
REQ-022 SHALL, in CLR, assert sfu_clr for one cycle, set kij=0, then go to READ.
REQ-023 SHALL, in each READ cycle, drive sram_cen=0, sram_wen=1, sram_addr=kij*o_ni_dim+o_idx and increment kij; after kij=kij_num-1 go to DRAIN.
REQ-024 SHALL assert sfu_acc exactly in the cycle after each read (READ cycles 2..kij_num and DRAIN), giving kij_num acc pulses per pixel.
REQ-025 SHALL go from DRAIN to RELU if the captured relu_en=1, else to WRITE; RELU SHALL assert sfu_relu one cycle then go to WRITE.
REQ-026 SHALL, in WRITE, drive sram_cen=0, sram_wen=0, sram_addr=kij_num*o_ni_dim+o_idx, sram_d=sfu_out.
REQ-027 SHALL, after WRITE, go to DONE if o_idx=o_ni_dim-1, else increment o_idx and go to CLR.
REQ-028 SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-029 SHALL take kij_num+3 (no ReLU) or kij_num+4 (ReLU) cycles per pixel, from CLR through WRITE.
REQ-030 SHALL never assert more than one of sfu_clr, sfu_acc, sfu_relu in the same cycle.
REQ-031 SHALL never read and write the SRAM in the same cycle; sram_cen SHALL be 1 outside READ and WRITE.
REQ-032 SHALL keep all address arithmetic unsigned and SHALL NOT wrap, given kij_num*o_ni_dim+o_ni_dim <= 2^addr_bw.

Reset
REQ-033 SHALL, on reset=0 at a clock edge, from any state, enter IDLE and clear kij, o_idx and the captured relu_en.
REQ-034 SHALL hold these output values while in reset: busy=0, done=0, sram_cen=1, sram_wen=1, sram_addr=0, sfu_acc=0, sfu_relu=0, sfu_clr=1.
REQ-035 SHALL, on reset mid-run, perform no SRAM write after the reset edge and leave the aborted pixel unwritten.

Structure
REQ-036 SHALL place the state encoding and the default parameter constants in shared package sfu_pkg.
REQ-037 SHALL contain one sub-module, sfu_addr_gen, holding the kij/o_idx counters and the read/write address computation.

Verification
REQ-038 Default parameters, relu_en=0, SRAM preloaded word(kij,o) = kij+1 in every lane -> each of out addresses 144..159 written with 45 in every lane; done pulses after 16*12+1 cycles.
REQ-039 relu_en=1, word(kij,o) = -(kij+1) in every lane -> all outputs written as 0; 16*13 cycles from CLR to the last WRITE.
REQ-040 start held high for the whole run -> exactly one run, and a second run starts the cycle after DONE.
REQ-041 reset=0 during READ of pixel 5 -> IDLE next cycle, no writes to 149..159, and sfu_clr=1 while reset is held.
REQ-042 Every cycle of every run -> assertion that sram_cen=0 together with sram_wen=0 occurs only in WRITE, and that at most one SFU strobe is high.
REQ-043 relu_en toggled mid-run -> behaviour of the run follows the value captured at start.

Source files
------------

// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared state encoding and default constants for the SFU controller
// Purpose: FSM state type and default parameter values used by sfu_ctrl,
//          sfu_addr_gen and sfu_ctrl_if.
// Ports:   none (package).
package sfu_pkg;

  localparam int PSUM_BW  = 16;  // bits per partial sum
  localparam int COL      = 8;   // SFU lanes per SRAM word
  localparam int KIJ_NUM  = 9;   // kernel positions accumulated per output
  localparam int O_NI_DIM = 16;  // output pixels per run
  localparam int ADDR_BW  = 11;  // psum SRAM address width

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    READ,
    DRAIN,
    RELU,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/sfu_ctrl_if.sv
// rtl/sfu_ctrl_if.sv - psum SRAM and SFU lane bundle
// Purpose: groups the SRAM bus and SFU strobes/data between the controller
//          and the memory/SFU side.
// Ports:   none; modport master = controller side, slave = SRAM/SFU side.
interface sfu_ctrl_if
  import sfu_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int addr_bw = ADDR_BW
) ();

  logic                     sram_cen;
  logic                     sram_wen;
  logic [addr_bw-1:0]       sram_addr;
  logic [col*psum_bw-1:0]   sram_q;
  logic [col*psum_bw-1:0]   sram_d;
  logic [col*psum_bw-1:0]   sfu_in;
  logic [col*psum_bw-1:0]   sfu_out;
  logic                     sfu_clr;
  logic                     sfu_acc;
  logic                     sfu_relu;

  modport master (
    output sram_cen, sram_wen, sram_addr, sram_d, sfu_in, sfu_clr, sfu_acc, sfu_relu,
    input  sram_q, sfu_out
  );

  modport slave (
    input  sram_cen, sram_wen, sram_addr, sram_d, sfu_in, sfu_clr, sfu_acc, sfu_relu,
    output sram_q, sfu_out
  );

endinterface

// File: rtl/sfu_addr_gen.sv
// rtl/sfu_addr_gen.sv - kij / o_idx counters and psum SRAM address computation
// Purpose: holds the kernel-position and output-pixel counters and forms the
//          read address kij*o_ni_dim+o_idx and write address kij_num*o_ni_dim+o_idx.
// Ports:   clk, reset (sync active-low); o_clr_i/o_inc_i, kij_clr_i/kij_inc_i
//          counter controls; kij_zero_o, kij_last_o, o_last_o status;
//          rd_addr_o, wr_addr_o addresses.
module sfu_addr_gen
  import sfu_pkg::*;
#(
  parameter int kij_num  = KIJ_NUM,
  parameter int o_ni_dim = O_NI_DIM,
  parameter int addr_bw  = ADDR_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               o_clr_i,
  input  logic               o_inc_i,
  input  logic               kij_clr_i,
  input  logic               kij_inc_i,
  output logic               kij_zero_o,
  output logic               kij_last_o,
  output logic               o_last_o,
  output logic [addr_bw-1:0] rd_addr_o,
  output logic [addr_bw-1:0] wr_addr_o
);

  localparam int KW = (kij_num  > 1) ? $clog2(kij_num)  : 1;
  localparam int OW = (o_ni_dim > 1) ? $clog2(o_ni_dim) : 1;

  logic [KW-1:0] kij_q, kij_d;
  logic [OW-1:0] o_idx_q, o_idx_d;

  always_comb begin
    kij_d = kij_q;
    if (kij_clr_i)      kij_d = '0;
    else if (kij_inc_i) kij_d = kij_q + KW'(1);
  end

  always_comb begin
    o_idx_d = o_idx_q;
    if (o_clr_i)      o_idx_d = '0;
    else if (o_inc_i) o_idx_d = o_idx_q + OW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      kij_q   <= '0;
      o_idx_q <= '0;
    end else begin
      kij_q   <= kij_d;
      o_idx_q <= o_idx_d;
    end
  end

  assign kij_zero_o = (kij_q == '0);
  assign kij_last_o = (kij_q == KW'(kij_num - 1));
  assign o_last_o   = (o_idx_q == OW'(o_ni_dim - 1));

  // Output region sits directly above the kij_num input planes.
  assign rd_addr_o = addr_bw'(kij_q) * addr_bw'(o_ni_dim) + addr_bw'(o_idx_q);
  assign wr_addr_o = addr_bw'(kij_num * o_ni_dim) + addr_bw'(o_idx_q);

endmodule

// File: rtl/sfu_ctrl.sv
// rtl/sfu_ctrl.sv - SFU controller: accumulate psums, optional ReLU, write back
// Purpose: per output pixel clears the SFU, reads kij_num psum words, drains
//          the last read, optionally applies ReLU and writes the result back.
// Ports:   clk, reset (sync active-low); start, relu_en run request;
//          busy, done status; bus (sfu_ctrl_if.master) SRAM + SFU signals.
module sfu_ctrl
  import sfu_pkg::*;
#(
  parameter int psum_bw  = PSUM_BW,
  parameter int col      = COL,
  parameter int kij_num  = KIJ_NUM,
  parameter int o_ni_dim = O_NI_DIM,
  parameter int addr_bw  = ADDR_BW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         relu_en,
  output logic         busy,
  output logic         done,
  sfu_ctrl_if.master   bus
);

  localparam int DW = col * psum_bw;

  state_e state_q, state_d;
  logic   relu_q, relu_d;

  logic               o_clr, o_inc, kij_clr, kij_inc;
  logic               kij_zero, kij_last, o_last;
  logic [addr_bw-1:0] rd_addr, wr_addr, addr;
  logic               cen, wen, clr, acc, relu;
  logic [DW-1:0]      lane_data;

  sfu_addr_gen #(
    .kij_num  (kij_num),
    .o_ni_dim (o_ni_dim),
    .addr_bw  (addr_bw)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .o_clr_i    (o_clr),
    .o_inc_i    (o_inc),
    .kij_clr_i  (kij_clr),
    .kij_inc_i  (kij_inc),
    .kij_zero_o (kij_zero),
    .kij_last_o (kij_last),
    .o_last_o   (o_last),
    .rd_addr_o  (rd_addr),
    .wr_addr_o  (wr_addr)
  );

  always_comb begin
    state_d = state_q;
    relu_d  = relu_q;
    o_clr   = 1'b0;
    o_inc   = 1'b0;
    kij_clr = 1'b0;
    kij_inc = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    cen     = 1'b1;
    wen     = 1'b1;
    addr    = '0;
    clr     = 1'b0;
    acc     = 1'b0;
    relu    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLR;
          relu_d  = relu_en;
          o_clr   = 1'b1;
        end
      end
      CLR: begin
        clr     = 1'b1;
        kij_clr = 1'b1;
        state_d = READ;
      end
      READ: begin
        cen     = 1'b0;
        addr    = rd_addr;
        kij_inc = 1'b1;
        // Read data lands one cycle later, so the first READ has nothing to add.
        acc     = !kij_zero;
        if (kij_last) state_d = DRAIN;
      end
      DRAIN: begin
        acc     = 1'b1;
        state_d = relu_q ? RELU : WRITE;
      end
      RELU: begin
        relu    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        cen  = 1'b0;
        wen  = 1'b0;
        addr = wr_addr;
        if (o_last) begin
          state_d = DONE;
        end else begin
          o_inc   = 1'b1;
          state_d = CLR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset overrides the outputs immediately, so an aborted run cannot write.
    if (!reset) begin
      busy = 1'b0;
      done = 1'b0;
      cen  = 1'b1;
      wen  = 1'b1;
      addr = '0;
      clr  = 1'b1;
      acc  = 1'b0;
      relu = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      relu_q  <= relu_d;
    end
  end

  assign lane_data     = bus.sfu_out;
  assign bus.sram_d    = lane_data;
  assign bus.sfu_in    = bus.sram_q;
  assign bus.sram_cen  = cen;
  assign bus.sram_wen  = wen;
  assign bus.sram_addr = addr;
  assign bus.sfu_clr   = clr;
  assign bus.sfu_acc   = acc;
  assign bus.sfu_relu  = relu;

endmodule

// File: tb/tb_sfu_ctrl.sv
// tb/tb_sfu_ctrl.sv - self-checking bench for sfu_ctrl
module tb_sfu_ctrl;

  localparam int K  = 9;
  localparam int O  = 16;
  localparam int PB = 16;
  localparam int C  = 8;
  localparam int AB = 11;
  localparam int W  = C * PB;

  logic clk = 1'b0;
  logic reset, start, relu_en;
  logic busy, done;

  always #5 clk = ~clk;

  sfu_ctrl_if #(.psum_bw(PB), .col(C), .addr_bw(AB)) bus ();

  sfu_ctrl #(
    .psum_bw(PB), .col(C), .kij_num(K), .o_ni_dim(O), .addr_bw(AB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .bus(bus.master)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int rise_cyc, done_cyc, last_wr;
  bit busy_prev = 0;
  bit cmp_en = 0;

  logic [W-1:0] mem [0:2**AB-1];
  logic [W-1:0] sfu_reg;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input logic [PB-1:0] v);
    logic [W-1:0] r;
    for (int l = 0; l < C; l++) r[l*PB +: PB] = v;
    return r;
  endfunction

  // Lane-wise sum of the K input words for pixel p, clamped when ReLU applies.
  function automatic logic [W-1:0] exp_word(input int p, input bit rl);
    logic [W-1:0] r;
    logic [PB-1:0] s;
    logic [W-1:0] w;
    for (int l = 0; l < C; l++) begin
      s = '0;
      for (int k = 0; k < K; k++) begin
        w = mem[k*O + p];
        s = s + w[l*PB +: PB];
      end
      if (rl && s[PB-1]) s = '0;
      r[l*PB +: PB] = s;
    end
    return r;
  endfunction

  task automatic preload(input bit neg);
    for (int k = 0; k < K; k++)
      for (int o = 0; o < O; o++)
        mem[k*O + o] = splat(neg ? PB'(-(k + 1)) : PB'(k + 1));
    for (int o = 0; o < O; o++) mem[K*O + o] = splat(16'hDEAD);
  endtask

  // SRAM with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.sram_cen && !bus.sram_wen) begin
      mem[bus.sram_addr] = bus.sram_d;
      wr_cnt++;
    end
    if (!bus.sram_cen && bus.sram_wen) bus.sram_q <= mem[bus.sram_addr];
  end

  // SFU lanes: registered clear / accumulate / ReLU.
  always @(posedge clk) begin
    logic [W-1:0] n;
    n = sfu_reg;
    for (int l = 0; l < C; l++) begin
      if (bus.sfu_clr)       n[l*PB +: PB] = '0;
      else if (bus.sfu_acc)  n[l*PB +: PB] = n[l*PB +: PB] + bus.sfu_in[l*PB +: PB];
      else if (bus.sfu_relu && n[l*PB + PB - 1]) n[l*PB +: PB] = '0;
    end
    sfu_reg <= n;
  end
  assign bus.sfu_out = sfu_reg;

  // Behavioural model: a run is a count of cycles since acceptance;
  // each pixel takes L cycles and a final done cycle follows.
  bit m_busy = 0;
  bit m_relu = 0;
  int m_cyc  = 0;

  always @(posedge clk) begin
    int total;
    total = O * (K + 3 + (m_relu ? 1 : 0)) + 1;
    if (!reset) m_busy <= 0;
    else if (!m_busy) begin
      if (start) begin
        m_busy <= 1;
        m_cyc  <= 0;
        m_relu <= relu_en;
      end
    end else if (m_cyc == total - 1) m_busy <= 0;
    else m_cyc <= m_cyc + 1;
  end

  always @(negedge clk) begin
    int L, p, ph, e_addr;
    bit e_busy, e_done, e_cen, e_wen, e_clr, e_acc, e_relu, e_wr;
    L = K + 3 + (m_relu ? 1 : 0);
    e_busy = 0; e_done = 0; e_cen = 1; e_wen = 1; e_clr = 0; e_acc = 0; e_relu = 0;
    e_wr = 0; e_addr = 0; p = 0;
    if (!reset) begin
      e_clr = 1;
    end else if (m_busy) begin
      e_busy = 1;
      if (m_cyc == O * L) e_done = 1;
      else begin
        p  = m_cyc / L;
        ph = m_cyc % L;
        e_clr = (ph == 0);
        if (ph >= 1 && ph <= K) begin
          e_cen = 0; e_addr = (ph - 1) * O + p;
        end
        e_acc  = (ph >= 2 && ph <= K + 1);
        e_relu = m_relu && (ph == K + 2);
        if (ph == L - 1) begin
          e_cen = 0; e_wen = 0; e_wr = 1; e_addr = K * O + p;
        end
      end
    end
    if (cmp_en) begin
      chk("busy", W'(busy), W'(e_busy));
      chk("done", W'(done), W'(e_done));
      chk("sram_cen", W'(bus.sram_cen), W'(e_cen));
      chk("sram_wen", W'(bus.sram_wen), W'(e_wen));
      chk("sfu_clr", W'(bus.sfu_clr), W'(e_clr));
      chk("sfu_acc", W'(bus.sfu_acc), W'(e_acc));
      chk("sfu_relu", W'(bus.sfu_relu), W'(e_relu));
      chk("sfu_in", bus.sfu_in, bus.sram_q);
      chk("strobe_1hot", W'($countones({bus.sfu_clr, bus.sfu_acc, bus.sfu_relu}) <= 1), W'(1));
      if (!reset || !e_cen) chk("sram_addr", W'(bus.sram_addr), W'(e_addr));
      if (e_wr) chk("sram_d", bus.sram_d, exp_word(p, m_relu));
    end
  end

  always @(negedge clk) begin
    if (busy && !busy_prev) rise_cyc = cyc;
    if (done) done_cyc = cyc;
    if (!bus.sram_cen && !bus.sram_wen) last_wr = cyc;
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", W'(seen), W'(1));
  endtask

  task automatic run(input bit rl, input int toggle_at);
    wr_cnt = 0;
    start = 1; relu_en = rl;
    tick(1);
    start = 0;
    tick(toggle_at);
    relu_en = !rl;
    wait_done(400);
    @(posedge clk); #2;
    relu_en = 0;
  endtask

  initial begin
    bit found;
    reset = 0; start = 0; relu_en = 0;
    bus.sram_q = '0;
    sfu_reg = '0;
    preload(0);
    @(negedge clk);
    cmp_en = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_sfu_clr", W'(bus.sfu_clr), W'(1));
      chk("rst_cen", W'(bus.sram_cen), W'(1));
    end
    @(posedge clk); #2;
    reset = 1;
    tick(2);

    // Positive data, no ReLU: every lane sums 1..9 = 45.
    run(0, 40);
    chk("A_latency", W'(done_cyc - (rise_cyc - 1)), W'(193));
    chk("A_writes", W'(wr_cnt), W'(16));
    for (int p = 0; p < O; p++) chk("A_out", mem[144 + p], splat(16'd45));

    // Negative data with ReLU captured at start, relu_en dropped mid-run.
    preload(1);
    run(1, 20);
    chk("B_span", W'(last_wr - rise_cyc + 1), W'(208));
    chk("B_writes", W'(wr_cnt), W'(16));
    for (int p = 0; p < O; p++) chk("B_out", mem[144 + p], splat(16'h0000));

    // Negative data without ReLU, relu_en raised mid-run: -45 = 0xFFD3.
    preload(1);
    run(0, 30);
    for (int p = 0; p < O; p++) chk("C_out", mem[144 + p], splat(16'hFFD3));

    // start held high: one full run, then a restart straight after DONE.
    preload(0);
    start = 1;
    wait_done(400);
    for (int o = 0; o < O; o++) mem[K*O + o] = splat(16'hDEAD);
    wr_cnt = 0;
    @(negedge clk);
    chk("D_gap_idle", W'(busy), W'(0));
    @(negedge clk);
    chk("D_restart", W'(busy), W'(1));
    chk("D_restart_clr", W'(bus.sfu_clr), W'(1));
    @(posedge clk); #2;
    start = 0;

    // Reset during READ of pixel 5 of the second run.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_busy && m_cyc == 5 * 12 + 3) found = 1;
    end
    chk("D_reach_px5", W'(found), W'(1));
    @(posedge clk); #2;
    reset = 0;
    repeat (2) begin
      @(negedge clk);
      chk("D_rst_clr", W'(bus.sfu_clr), W'(1));
      chk("D_rst_busy", W'(busy), W'(0));
    end
    @(posedge clk); #2;
    reset = 1;
    tick(5);
    chk("D_idle", W'(busy), W'(0));
    chk("D_writes", W'(wr_cnt), W'(5));
    for (int p = 0; p < O; p++)
      chk("D_out", mem[144 + p], (p < 5) ? splat(16'd45) : splat(16'hDEAD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
